bram_loader: RTL
================

// Module: bram_loader
// PURPOSE
//  Upstream write stage for the bram test-vector store. Accepts a byte stream over a valid/ready
//  handshake and writes it to consecutive BRAM addresses from a programmable base.
//  Keeps a running XOR checksum of the bytes written. Optionally reads the region back and
//  compares checksums, then reports done/error to the tester sequencer.
// PARAMETERS
//  ADDR_W     17  BRAM address width; addresses wrap modulo 2**ADDR_W
//  DATA_W     8   byte width
//  VERIFY_EN  1   1: readback-verify pass after load; 0: skip it
// PORTS
//  clk            in   1         single clock, all state on posedge
//  rst            in   1         asynchronous, active-high reset
//  start          in   1         1-cycle command pulse; sampled only in IDLE
//  base_addr      in   ADDR_W    first write address, latched on start
//  length         in   ADDR_W+1  byte count, 0..2**ADDR_W, latched on start
//  in_valid       in   1         stream byte valid
//  in_ready       out  1         loader accepts byte (== state LOAD)
//  in_data        in   DATA_W    stream byte
//  busy           out  1         high in LOAD/VERIFY/DRAIN
//  done           out  1         1-cycle pulse at end of command
//  error          out  1         verify mismatch; held until next accepted start
//  checksum       out  DATA_W    XOR of written bytes; held until next accepted start
//  bram_mode      out  1         0 read, 1 write (to bram.mode)
//  bram_address   out  ADDR_W    to bram.address
//  bram_byte_in   out  DATA_W    to bram.byte_in
//  bram_byte_out  in   DATA_W    from bram.byte_out; valid 1 cycle after read address presented
// BEHAVIOUR
//  Reset (async): state=IDLE. Outputs 0: in_ready, busy, done, error, checksum, bram_mode,
//    bram_address, bram_byte_in. All bram_* outputs are registered.
//  States: IDLE -> LOAD -> (VERIFY -> DRAIN if VERIFY_EN) -> DONE -> IDLE.
//  IDLE:
//   - On start: latch base_addr/length; clear cnt, checksum, error.
//   - length==0: go to DONE; no BRAM writes.
//   - Otherwise go to LOAD.
//  LOAD: in_ready=1.
//   - Byte accepted at edge N (in_valid & in_ready): edge N drives bram_mode=1,
//     bram_address=(base+cnt) mod 2**ADDR_W, bram_byte_in=in_data. BRAM commits at edge N+1.
//   - On acceptance: checksum^=in_data; cnt++.
//   - Cycle with no accepted byte: bram_mode=0, address/byte_in hold. Throughput 1 byte/cycle.
//   - Last byte (cnt==length-1) accepted: go to VERIFY (VERIFY_EN=1) or DONE.
//     in_ready is low in the next cycle.
//  VERIFY: bram_mode=0.
//   - Present read addresses base..base+length-1 (wrapping), one per cycle.
//   - Capture bram_byte_out one cycle after each address; XOR into vsum.
//   - After the last address is issued, go to DRAIN.
//  DRAIN: capture the final read byte; error = (vsum^last != checksum); go to DONE.
//  DONE: done=1 for exactly one cycle; busy=0; bram_mode=0; go to IDLE.
//  start while not IDLE is ignored; latched parameters are unchanged.
//  Reset mid-operation: immediate return to IDLE, bram_mode=0; bytes already written remain in BRAM.
//  cnt is ADDR_W+1 bits, so a full 2**ADDR_W load terminates correctly.
// TESTING
//  1. base=0, len=4, bytes 60,11,22,33 back-to-back -> writes at addr 0..3; checksum=0x60;
//     4 reads; error=0; single done pulse.
//  2. Same load with in_valid low 2 cycles between bytes -> bram_mode=0 during gaps;
//     addresses still 0,1,2,3; result as in 1.
//  3. base=0x1FFFE, len=3 -> write addresses 1FFFE, 1FFFF, 00000; readback follows the same wrap.
//  4. len=0 -> done pulses 2 cycles after start; bram_mode never 1; checksum=0.
//  5. Bench BRAM model flips bit 0 of addr 2 during verify -> error=1 at done;
//     next start with good data clears error.
//  6. rst asserted mid-LOAD after 2 bytes -> bram_mode=0 and busy=0 immediately;
//     start during busy ignored (length unchanged).

Source files
------------

// File: rtl/bram_loader.sv
// rtl/bram_loader.sv - stream-to-BRAM loader with XOR checksum and optional readback verify
//
// Purpose: accepts a byte stream on a valid/ready handshake, writes consecutive
// BRAM addresses starting at a latched base (wrapping modulo 2**ADDR_W), keeps
// an XOR checksum of written bytes, optionally reads the region back and flags
// a checksum mismatch, then pulses done.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start               command pulse, sampled only while idle
//   base_addr, length   command parameters, latched on an accepted start
//   in_valid, in_ready, in_data   byte stream handshake
//   busy, done, error, checksum   status to the tester sequencer
//   bram_mode, bram_address, bram_byte_in, bram_byte_out   BRAM port

module bram_loader #(
    parameter int ADDR_W    = 17,
    parameter int DATA_W    = 8,
    parameter int VERIFY_EN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [DATA_W-1:0] checksum,
    output logic              bram_mode,
    output logic [ADDR_W-1:0] bram_address,
    output logic [DATA_W-1:0] bram_byte_in,
    input  logic [DATA_W-1:0] bram_byte_out
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_VERIFY,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

    state_t              state_q;
    logic [ADDR_W-1:0]   base_q;
    logic [ADDR_W:0]     len_q;
    logic [ADDR_W:0]     cnt_q;
    logic [DATA_W-1:0]   csum_q;
    logic [DATA_W-1:0]   vsum_q;
    logic                err_q;
    logic                done_q;
    logic                mode_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   byte_q;
    // Read pipeline: rv1_q = address issued last edge (BRAM samples it next edge),
    // rv2_q = BRAM has registered that read, bram_byte_out is valid this cycle.
    logic                rv1_q;
    logic                rv2_q;

    logic [ADDR_W-1:0]   cur_addr_d;
    logic                last_d;

    // Counter is one bit wider than the address so a full 2**ADDR_W length terminates.
    assign cur_addr_d = base_q + cnt_q[ADDR_W-1:0];
    assign last_d     = (cnt_q == (len_q - CNT_ONE));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            base_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            csum_q  <= '0;
            vsum_q  <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            mode_q  <= 1'b0;
            addr_q  <= '0;
            byte_q  <= '0;
            rv1_q   <= 1'b0;
            rv2_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            mode_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        base_q  <= base_addr;
                        len_q   <= length;
                        cnt_q   <= '0;
                        csum_q  <= '0;
                        vsum_q  <= '0;
                        err_q   <= 1'b0;
                        rv1_q   <= 1'b0;
                        rv2_q   <= 1'b0;
                        state_q <= (length == '0) ? S_DONE : S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (in_valid) begin
                        mode_q <= 1'b1;
                        addr_q <= cur_addr_d;
                        byte_q <= in_data;
                        csum_q <= csum_q ^ in_data;
                        if (last_d) begin
                            cnt_q   <= '0;
                            state_q <= (VERIFY_EN != 0) ? S_VERIFY : S_DONE;
                        end else begin
                            cnt_q <= cnt_q + CNT_ONE;
                        end
                    end
                end
                S_VERIFY: begin
                    addr_q <= cur_addr_d;
                    cnt_q  <= cnt_q + CNT_ONE;
                    rv1_q  <= 1'b1;
                    rv2_q  <= rv1_q;
                    if (rv2_q) begin
                        vsum_q <= vsum_q ^ bram_byte_out;
                    end
                    if (last_d) begin
                        state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // Let in-flight reads retire; the last one settles the verdict.
                    rv1_q <= 1'b0;
                    rv2_q <= rv1_q;
                    if (rv2_q) begin
                        if (rv1_q) begin
                            vsum_q <= vsum_q ^ bram_byte_out;
                        end else begin
                            err_q   <= ((vsum_q ^ bram_byte_out) != csum_q);
                            state_q <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready     = (state_q == S_LOAD);
    assign busy         = (state_q == S_LOAD) || (state_q == S_VERIFY) || (state_q == S_DRAIN);
    assign done         = done_q;
    assign error        = err_q;
    assign checksum     = csum_q;
    assign bram_mode    = mode_q;
    assign bram_address = addr_q;
    assign bram_byte_in = byte_q;

endmodule
